nv_nvdla_cmac_sc_rx: RTL and testbench
======================================

Name: nv_nvdla_cmac_sc_rx

Overview:
- Receiving end of the sc2mac weight/data interface, at the CMAC input after the csc2cmac retiming stage.
- Weight beats arrive with a one-hot cell select and are written into per-cell shadow weight registers.
- A data beat with stripe_st set promotes all shadow weights to active weights.
- Outputs registered, mask-zeroed data plus the active weight set to the MAC cells, 1-cycle latency.

Parameters:
- ATOMC, 8, elements per beat (mask width).
- BPE, 8, bits per element.
- ATOMK_HF, 4, number of MAC cells (wt_sel width).

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  reset; one clock, synchronous, active-high
- sc2mac_wt_pvld  in  1  weight beat valid
- sc2mac_wt_mask  in  ATOMC  element valid mask
- sc2mac_wt_data  in  ATOMC*BPE  weight elements, element k at [k*BPE+:BPE]
- sc2mac_wt_sel  in  ATOMK_HF  one-hot target cell
- sc2mac_dat_pvld  in  1  data beat valid
- sc2mac_dat_mask  in  ATOMC  element valid mask
- sc2mac_dat_data  in  ATOMC*BPE  data elements
- sc2mac_dat_pd  in  9  [5:0] batch_idx, [6] stripe_st, [7] stripe_end, [8] layer_end
- mac_dat_pvld  out  1  data valid to cells
- mac_dat_data  out  ATOMC*BPE  data, masked elements forced to 0
- mac_dat_pd  out  9  registered pd
- mac_wt_actv_data  out  ATOMK_HF*ATOMC*BPE  active weights, cell i at [i*ATOMC*BPE+:ATOMC*BPE]
- mac_wt_actv_vld  out  ATOMK_HF  cell holds valid active weights
- mac_layer_done  out  1  1-cycle pulse after a layer_end beat
- rx_sel_err  out  1  sticky: wt_pvld with sel not one-hot

Behaviour:
- Reset: all outputs 0; shadow and active weights 0; shadow_vld and actv_vld 0.
- The interface has no backpressure. The block must accept every pvld cycle.
- Weight write, when wt_pvld is set and sel is one-hot (cell i):
  - shadow[i] element k <= mask[k] ? data[k] : 0.
  - shadow_vld[i] <= 1.
- Bad weight beat, when wt_pvld is set and sel is zero or has more than one bit:
  - No write.
  - rx_sel_err <= 1; cleared only by reset.
- Swap, when dat_pvld and pd[6] are set:
  - active <= shadow for all cells.
  - actv_vld <= shadow_vld.
  - shadow_vld <= 0, except bits written by a weight beat in the same cycle.
- Simultaneous weight write and swap:
  - The swap copies the pre-write shadow value.
  - The write lands in shadow and belongs to the next stripe.
  - shadow_vld for that cell stays 1.
- Cell with no shadow write since the last swap: active is still overwritten with its shadow contents, and actv_vld[i] = 0.
- Data path, latency 1:
  - mac_dat_pvld <= dat_pvld.
  - When dat_pvld is set: mac_dat_data <= masked data, mac_dat_pd <= pd.
  - When dat_pvld is clear: mac_dat_data and mac_dat_pd hold.
- Swap timing: the active weights seen with a stripe_st beat on the output are the swapped set, in the same output cycle.
- Data beats before any swap: mac_dat_pvld follows the input; actv_vld = 0.
- mac_layer_done <= dat_pvld & pd[8]. Nothing is cleared by it.
- Reset mid-stream: everything returns to reset state next cycle; in-flight beats are dropped.

Optional Feature:
- Macro: NVDLA_CMAC_RX_STAT_EN.
- Enabled:
  - Adds outputs rx_wt_beat_cnt[15:0] and rx_dat_beat_cnt[15:0], counting accepted weight beats (valid sel only) and data beats.
  - Both counters saturate at 0xFFFF and reset to 0.
  - Both clear the cycle after mac_layer_done pulses. A beat in the clearing cycle counts as 1.
- Disabled: ports and logic absent; all other behaviour identical.

Test Plan:
- Weight load and swap:
  - Stimulus: wt sel=4'b0001 mask=0xFF data=0x01..0x08; then dat pvld with pd[6]=1.
  - Response: next cycle mac_wt_actv_vld=4'b0001 and cell0 active=0x0807060504030201.
- Masking:
  - Stimulus: dat mask=8'h0F, all elements 0xAA.
  - Response: mac_dat_data=0x00000000AAAAAAAA one cycle later, mac_dat_pvld=1.
- Simultaneous write and swap:
  - Stimulus: cell1 shadow=A; same cycle: wt write B to cell1 plus stripe_st beat; then a second stripe_st beat.
  - Response: after the first swap, active cell1=A; after the second, active cell1=B.
- Bad select:
  - Stimulus: wt_pvld with sel=4'b0011.
  - Response: no shadow change; rx_sel_err=1 and stays 1 until reset.
- Layer end with counters (STAT_EN):
  - Stimulus: 3 weight beats and 5 data beats, the last with pd[8]=1.
  - Response: mac_layer_done pulses once; counters read 3/5, then 0 the cycle after the pulse.
- Mid-stream reset:
  - Stimulus: assert nvdla_core_rst during a data burst.
  - Response: next cycle all outputs 0 and actv_vld=0.

Source files
------------

// File: rtl/nv_nvdla_cmac_sc_rx_if.sv
// sc2mac receive bundle: weight/data beats in, masked data and active weights out.
// Latency: none (wires only).
// Backpressure: none; the producer side never stalls, so there is no ready.
// NVDLA_CMAC_RX_STAT_EN adds the two beat counters to the bundle.
interface nv_nvdla_cmac_sc_rx_if #(
  parameter int ATOMC    = 8,
  parameter int BPE      = 8,
  parameter int ATOMK_HF = 4
) ();

  // upstream weight beat
  logic                         sc2mac_wt_pvld;
  logic [ATOMC-1:0]             sc2mac_wt_mask;
  logic [ATOMC*BPE-1:0]         sc2mac_wt_data;
  logic [ATOMK_HF-1:0]          sc2mac_wt_sel;

  // upstream data beat
  logic                         sc2mac_dat_pvld;
  logic [ATOMC-1:0]             sc2mac_dat_mask;
  logic [ATOMC*BPE-1:0]         sc2mac_dat_data;
  logic [8:0]                   sc2mac_dat_pd;

  // towards the MAC cells
  logic                         mac_dat_pvld;
  logic [ATOMC*BPE-1:0]         mac_dat_data;
  logic [8:0]                   mac_dat_pd;
  logic [ATOMK_HF*ATOMC*BPE-1:0] mac_wt_actv_data;
  logic [ATOMK_HF-1:0]          mac_wt_actv_vld;
  logic                         mac_layer_done;
  logic                         rx_sel_err;

`ifdef NVDLA_CMAC_RX_STAT_EN
  logic [15:0]                  rx_wt_beat_cnt;
  logic [15:0]                  rx_dat_beat_cnt;
`endif

  modport master (
    output sc2mac_wt_pvld, sc2mac_wt_mask, sc2mac_wt_data, sc2mac_wt_sel,
    output sc2mac_dat_pvld, sc2mac_dat_mask, sc2mac_dat_data, sc2mac_dat_pd,
    input  mac_dat_pvld, mac_dat_data, mac_dat_pd,
    input  mac_wt_actv_data, mac_wt_actv_vld, mac_layer_done, rx_sel_err
`ifdef NVDLA_CMAC_RX_STAT_EN
    , input rx_wt_beat_cnt, rx_dat_beat_cnt
`endif
  );

  modport slave (
    input  sc2mac_wt_pvld, sc2mac_wt_mask, sc2mac_wt_data, sc2mac_wt_sel,
    input  sc2mac_dat_pvld, sc2mac_dat_mask, sc2mac_dat_data, sc2mac_dat_pd,
    output mac_dat_pvld, mac_dat_data, mac_dat_pd,
    output mac_wt_actv_data, mac_wt_actv_vld, mac_layer_done, rx_sel_err
`ifdef NVDLA_CMAC_RX_STAT_EN
    , output rx_wt_beat_cnt, rx_dat_beat_cnt
`endif
  );

endinterface

// File: rtl/nv_nvdla_cmac_sc_rx.sv
// CMAC sc2mac receiver: shadow/active weight double buffer plus masked data retime.
// Latency: 1 cycle from sc2mac beat to mac outputs; a stripe_st swap shows with its data.
// Backpressure: none; every pvld cycle is consumed.
// Optional beat counters under NVDLA_CMAC_RX_STAT_EN.
module nv_nvdla_cmac_sc_rx #(
  parameter int ATOMC    = 8,
  parameter int BPE      = 8,
  parameter int ATOMK_HF = 4
) (
  input logic                   nvdla_core_clk,
  input logic                   nvdla_core_rst,
  nv_nvdla_cmac_sc_rx_if.slave  rx
);

  localparam int CW = ATOMC * BPE;

  // zero every element whose mask bit is clear
  function automatic logic [CW-1:0] mask_elems(input logic [CW-1:0] d,
                                               input logic [ATOMC-1:0] m);
    logic [CW-1:0] r;
    r = '0;
    for (int k = 0; k < ATOMC; k++) begin
      if (m[k]) r[k*BPE +: BPE] = d[k*BPE +: BPE];
    end
    return r;
  endfunction

  logic                wt_sel_ok;
  logic [ATOMK_HF-1:0] wt_wr;
  logic                swap;
  logic [CW-1:0]       wt_masked;
  logic [CW-1:0]       dat_masked;

  logic [CW-1:0]       shadow [ATOMK_HF];
  logic [CW-1:0]       active [ATOMK_HF];
  logic [ATOMK_HF-1:0] shadow_vld;
  logic [ATOMK_HF-1:0] actv_vld;

  logic                dat_pvld_q;
  logic [CW-1:0]       dat_data_q;
  logic [8:0]          dat_pd_q;
  logic                layer_done_q;
  logic                sel_err_q;

  assign wt_sel_ok  = $onehot(rx.sc2mac_wt_sel);
  assign swap       = rx.sc2mac_dat_pvld & rx.sc2mac_dat_pd[6];
  assign wt_masked  = mask_elems(rx.sc2mac_wt_data, rx.sc2mac_wt_mask);
  assign dat_masked = mask_elems(rx.sc2mac_dat_data, rx.sc2mac_dat_mask);

  // per-cell write strobe; a malformed select writes nothing
  always_comb begin
    wt_wr = '0;
    if (rx.sc2mac_wt_pvld && wt_sel_ok) wt_wr = rx.sc2mac_wt_sel;
  end

  // shadow weight storage, loaded by weight beats
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      for (int i = 0; i < ATOMK_HF; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < ATOMK_HF; i++) begin
        if (wt_wr[i]) shadow[i] <= wt_masked;
      end
    end
  end

  // shadow valid: a same-cycle write survives the swap and belongs to the next stripe
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) shadow_vld <= '0;
    else if (swap)      shadow_vld <= wt_wr;
    else                shadow_vld <= shadow_vld | wt_wr;
  end

  // active weights take the pre-write shadow set on a stripe_st beat
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      for (int i = 0; i < ATOMK_HF; i++) active[i] <= '0;
      actv_vld <= '0;
    end else if (swap) begin
      for (int i = 0; i < ATOMK_HF; i++) active[i] <= shadow[i];
      actv_vld <= shadow_vld;
    end
  end

  // data retime: valid follows input, payload holds between beats
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      dat_pvld_q <= 1'b0;
      dat_data_q <= '0;
      dat_pd_q   <= '0;
    end else begin
      dat_pvld_q <= rx.sc2mac_dat_pvld;
      if (rx.sc2mac_dat_pvld) begin
        dat_data_q <= dat_masked;
        dat_pd_q   <= rx.sc2mac_dat_pd;
      end
    end
  end

  // layer-end pulse and sticky select error
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      layer_done_q <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      layer_done_q <= rx.sc2mac_dat_pvld & rx.sc2mac_dat_pd[8];
      if (rx.sc2mac_wt_pvld && !wt_sel_ok) sel_err_q <= 1'b1;
    end
  end

  assign rx.mac_dat_pvld    = dat_pvld_q;
  assign rx.mac_dat_data    = dat_data_q;
  assign rx.mac_dat_pd      = dat_pd_q;
  assign rx.mac_wt_actv_vld = actv_vld;
  assign rx.mac_layer_done  = layer_done_q;
  assign rx.rx_sel_err      = sel_err_q;

  for (genvar g = 0; g < ATOMK_HF; g++) begin : g_actv
    assign rx.mac_wt_actv_data[g*CW +: CW] = active[g];
  end

`ifdef NVDLA_CMAC_RX_STAT_EN
  logic        wt_acc;
  logic [15:0] wt_cnt;
  logic [15:0] dat_cnt;

  assign wt_acc = |wt_wr;

  // saturating beat counters; restart the cycle after a layer_done pulse, counting that cycle's beat
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wt_cnt  <= '0;
      dat_cnt <= '0;
    end else if (layer_done_q) begin
      wt_cnt  <= {15'd0, wt_acc};
      dat_cnt <= {15'd0, rx.sc2mac_dat_pvld};
    end else begin
      if (wt_acc && wt_cnt != 16'hFFFF)                 wt_cnt  <= wt_cnt + 16'd1;
      if (rx.sc2mac_dat_pvld && dat_cnt != 16'hFFFF)    dat_cnt <= dat_cnt + 16'd1;
    end
  end

  assign rx.rx_wt_beat_cnt  = wt_cnt;
  assign rx.rx_dat_beat_cnt = dat_cnt;
`endif

endmodule

// File: tb/tb_nv_nvdla_cmac_sc_rx.sv
// Bench for nv_nvdla_cmac_sc_rx: directed vector table plus a layer-end sequence.
// Inputs change on the falling edge; outputs sampled 1 time unit after the rising edge.
// The DUT has no backpressure, so every driven beat is consumed.
module tb_nv_nvdla_cmac_sc_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  nv_nvdla_cmac_sc_rx_if #(.ATOMC(8), .BPE(8), .ATOMK_HF(4)) rx_if ();

  nv_nvdla_cmac_sc_rx #(.ATOMC(8), .BPE(8), .ATOMK_HF(4)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .rx             (rx_if)
  );

  typedef struct {
    logic         rst;
    logic         wt_pvld;
    logic [3:0]   wt_sel;
    logic [7:0]   wt_mask;
    logic [63:0]  wt_data;
    logic         dat_pvld;
    logic [7:0]   dat_mask;
    logic [63:0]  dat_data;
    logic [8:0]   dat_pd;
    logic         e_pvld;
    logic [63:0]  e_data;
    logic [8:0]   e_pd;
    logic [3:0]   e_avld;
    logic [255:0] e_actv;
    logic         e_done;
    logic         e_err;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic wp, input logic [3:0] ws, input logic [7:0] wm,
                              input logic [63:0] wd, input logic dp, input logic [7:0] dm, input logic [63:0] dd,
                              input logic [8:0] pd, input logic ep, input logic [63:0] ed, input logic [8:0] epd,
                              input logic [3:0] eav, input logic [255:0] eact, input logic edone, input logic eerr);
    vec_t v;
    v.rst = r; v.wt_pvld = wp; v.wt_sel = ws; v.wt_mask = wm; v.wt_data = wd;
    v.dat_pvld = dp; v.dat_mask = dm; v.dat_data = dd; v.dat_pd = pd;
    v.e_pvld = ep; v.e_data = ed; v.e_pd = epd; v.e_avld = eav; v.e_actv = eact;
    v.e_done = edone; v.e_err = eerr;
    return v;
  endfunction

  // input-only record for the hand-written sequence
  function automatic vec_t mkin(input logic r, input logic wp, input logic [3:0] ws,
                                input logic dp, input logic [8:0] pd);
    return mk(r, wp, ws, 8'hFF, 64'h0102030405060708, dp, 8'hFF, 64'h1122334455667788, pd,
              1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
  endfunction

  task automatic drive(input vec_t v);
    @(negedge clk);
    rst                      = v.rst;
    rx_if.sc2mac_wt_pvld     = v.wt_pvld;
    rx_if.sc2mac_wt_sel      = v.wt_sel;
    rx_if.sc2mac_wt_mask     = v.wt_mask;
    rx_if.sc2mac_wt_data     = v.wt_data;
    rx_if.sc2mac_dat_pvld    = v.dat_pvld;
    rx_if.sc2mac_dat_mask    = v.dat_mask;
    rx_if.sc2mac_dat_data    = v.dat_data;
    rx_if.sc2mac_dat_pd      = v.dat_pd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input vec_t v, input int idx);
    n_vec++;
    chk($sformatf("v%0d mac_dat_pvld", idx),     256'(rx_if.mac_dat_pvld),     256'(v.e_pvld));
    chk($sformatf("v%0d mac_dat_data", idx),     256'(rx_if.mac_dat_data),     256'(v.e_data));
    chk($sformatf("v%0d mac_dat_pd", idx),       256'(rx_if.mac_dat_pd),       256'(v.e_pd));
    chk($sformatf("v%0d mac_wt_actv_vld", idx),  256'(rx_if.mac_wt_actv_vld),  256'(v.e_avld));
    chk($sformatf("v%0d mac_wt_actv_data", idx), rx_if.mac_wt_actv_data,       v.e_actv);
    chk($sformatf("v%0d mac_layer_done", idx),   256'(rx_if.mac_layer_done),   256'(v.e_done));
    chk($sformatf("v%0d rx_sel_err", idx),       256'(rx_if.rx_sel_err),       256'(v.e_err));
  endtask

  localparam logic [63:0] C0 = 64'h0807060504030201;
  localparam logic [63:0] WA = 64'h1A1A1A1A1A1A1A1A;
  localparam logic [63:0] WB = 64'h2B2B2B2B00000000;  // 0x2B.. loaded with mask 0xF0
  localparam logic [63:0] W2 = 64'h7700000000000066;  // 0x7711223344556666 loaded with mask 0x81
  localparam logic [63:0] Z  = 64'h0;

  vec_t tbl[18];

  initial begin
    rx_if.sc2mac_wt_pvld  = 1'b0;
    rx_if.sc2mac_wt_sel   = '0;
    rx_if.sc2mac_wt_mask  = '0;
    rx_if.sc2mac_wt_data  = '0;
    rx_if.sc2mac_dat_pvld = 1'b0;
    rx_if.sc2mac_dat_mask = '0;
    rx_if.sc2mac_dat_data = '0;
    rx_if.sc2mac_dat_pd   = '0;

    //             rst  wp   sel      wmask  wdata                  dp   dmask  ddata                  pd      ep   edata                  epd     eavld    eactv             done err
    tbl[0]  = mk(1'b1, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b0, 8'h00, 64'h0,                 9'h000, 1'b0, 64'h0,                 9'h000, 4'b0000, {Z, Z, Z, Z},     1'b0, 1'b0);
    tbl[1]  = mk(1'b0, 1'b1, 4'b0001, 8'hFF, C0,                    1'b0, 8'h00, 64'h0,                 9'h000, 1'b0, 64'h0,                 9'h000, 4'b0000, {Z, Z, Z, Z},     1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b1, 8'hFF, 64'h1111111111111111,  9'h040, 1'b1, 64'h1111111111111111,  9'h040, 4'b0001, {Z, Z, Z, C0},    1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b1, 8'h0F, 64'hAAAAAAAAAAAAAAAA,  9'h005, 1'b1, 64'h00000000AAAAAAAA,  9'h005, 4'b0001, {Z, Z, Z, C0},    1'b0, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b0, 8'hFF, 64'h9999999999999999,  9'h1FF, 1'b0, 64'h00000000AAAAAAAA,  9'h005, 4'b0001, {Z, Z, Z, C0},    1'b0, 1'b0);
    tbl[5]  = mk(1'b0, 1'b1, 4'b0010, 8'hFF, WA,                    1'b0, 8'h00, 64'h0,                 9'h000, 1'b0, 64'h00000000AAAAAAAA,  9'h005, 4'b0001, {Z, Z, Z, C0},    1'b0, 1'b0);
    tbl[6]  = mk(1'b0, 1'b1, 4'b0010, 8'hF0, 64'h2B2B2B2B2B2B2B2B,  1'b1, 8'hFF, 64'h0123456789ABCDEF,  9'h040, 1'b1, 64'h0123456789ABCDEF,  9'h040, 4'b0010, {Z, Z, WA, C0},   1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b1, 8'h00, 64'hFFFFFFFFFFFFFFFF,  9'h040, 1'b1, 64'h0,                 9'h040, 4'b0010, {Z, Z, WB, C0},   1'b0, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b1, 8'hFF, 64'h5555555555555555,  9'h040, 1'b1, 64'h5555555555555555,  9'h040, 4'b0000, {Z, Z, WB, C0},   1'b0, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 4'b0011, 8'hFF, 64'hFFFFFFFFFFFFFFFF,  1'b0, 8'h00, 64'h0,                 9'h000, 1'b0, 64'h5555555555555555,  9'h040, 4'b0000, {Z, Z, WB, C0},   1'b0, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b1, 8'hFF, 64'h0,                 9'h040, 1'b1, 64'h0,                 9'h040, 4'b0000, {Z, Z, WB, C0},   1'b0, 1'b1);
    tbl[11] = mk(1'b0, 1'b1, 4'b0000, 8'hFF, 64'hFFFFFFFFFFFFFFFF,  1'b0, 8'h00, 64'h0,                 9'h000, 1'b0, 64'h0,                 9'h040, 4'b0000, {Z, Z, WB, C0},   1'b0, 1'b1);
    tbl[12] = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b1, 8'h01, 64'hFFFFFFFFFFFFFFC3,  9'h100, 1'b1, 64'h00000000000000C3,  9'h100, 4'b0000, {Z, Z, WB, C0},   1'b1, 1'b1);
    tbl[13] = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b0, 8'h00, 64'h0,                 9'h000, 1'b0, 64'h00000000000000C3,  9'h100, 4'b0000, {Z, Z, WB, C0},   1'b0, 1'b1);
    tbl[14] = mk(1'b0, 1'b1, 4'b0100, 8'h81, 64'h7711223344556666,  1'b1, 8'hFF, 64'h1,                 9'h040, 1'b1, 64'h1,                 9'h040, 4'b0000, {Z, Z, WB, C0},   1'b0, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b1, 8'hFF, 64'h2,                 9'h0C0, 1'b1, 64'h2,                 9'h0C0, 4'b0100, {Z, W2, WB, C0},  1'b0, 1'b1);
    tbl[16] = mk(1'b1, 1'b1, 4'b0001, 8'hFF, 64'h3333333333333333,  1'b1, 8'hFF, 64'h3,                 9'h140, 1'b0, 64'h0,                 9'h000, 4'b0000, {Z, Z, Z, Z},     1'b0, 1'b0);
    tbl[17] = mk(1'b0, 1'b0, 4'b0000, 8'h00, 64'h0,                 1'b1, 8'hFF, 64'h4,                 9'h040, 1'b1, 64'h4,                 9'h040, 4'b0000, {Z, Z, Z, Z},     1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i]);
      check_vec(tbl[i], i);
    end

    // layer-end sequence: 3 weight beats, 5 data beats ending with layer_end, then a beat in the clearing cycle
    drive(mkin(1'b1, 1'b0, 4'b0000, 1'b0, 9'h000));
    for (int j = 0; j < 3; j++) begin
      drive(mkin(1'b0, 1'b1, (j == 2) ? 4'b1000 : 4'(1 << j), 1'b0, 9'h000));
      n_vec++;
      chk($sformatf("seq wt%0d layer_done", j), 256'(rx_if.mac_layer_done), 256'(0));
    end
`ifdef NVDLA_CMAC_RX_STAT_EN
    n_vec++;
    chk("seq wt_cnt after weights", 256'(rx_if.rx_wt_beat_cnt), 256'(3));
    chk("seq dat_cnt after weights", 256'(rx_if.rx_dat_beat_cnt), 256'(0));
`endif
    for (int j = 0; j < 5; j++) begin
      drive(mkin(1'b0, 1'b0, 4'b0000, 1'b1, (j == 4) ? 9'h100 : 9'h000));
      n_vec++;
      chk($sformatf("seq dat%0d layer_done", j), 256'(rx_if.mac_layer_done), 256'(j == 4));
      chk($sformatf("seq dat%0d actv_vld", j), 256'(rx_if.mac_wt_actv_vld), 256'(0));
    end
`ifdef NVDLA_CMAC_RX_STAT_EN
    n_vec++;
    chk("seq wt_cnt at pulse", 256'(rx_if.rx_wt_beat_cnt), 256'(3));
    chk("seq dat_cnt at pulse", 256'(rx_if.rx_dat_beat_cnt), 256'(5));
`endif
    drive(mkin(1'b0, 1'b0, 4'b0000, 1'b1, 9'h000));
    n_vec++;
    chk("seq clear layer_done", 256'(rx_if.mac_layer_done), 256'(0));
`ifdef NVDLA_CMAC_RX_STAT_EN
    chk("seq wt_cnt cleared", 256'(rx_if.rx_wt_beat_cnt), 256'(0));
    chk("seq dat_cnt restart", 256'(rx_if.rx_dat_beat_cnt), 256'(1));
`endif
    drive(mkin(1'b0, 1'b0, 4'b0000, 1'b0, 9'h000));
    n_vec++;
    chk("seq idle layer_done", 256'(rx_if.mac_layer_done), 256'(0));
    chk("seq idle pvld", 256'(rx_if.mac_dat_pvld), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // run-away guard
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog");
  end

endmodule
